lfsr_checker: RTL and testbench

Receive-side checker for the 16-bit Fibonacci LFSR pattern generator. Samples the generator's `Q_out` stream, self-seeds from the first valid word and locks onto the sequence. Once locked, it flags and counts mismatches, detects the all-zero lockup word and confirms full 65535-word periods. It sits on the far end of the generator link, either in loopback on the Basys3 or across a board-to-board link, and drives status LEDs and a debug counter.

---
 rtl/lfsr_checker.sv | 159 +++++++++++++++
 tb/tb_lfsr_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the x^16+x^15+x^13+x^4+1 Fibonacci LFSR stream.
// Define LFSR_CHK_TICK_EN to compile in the max_tick_in agreement check.
module lfsr_checker #(
  parameter int          LOCK_COUNT = 4,
  parameter int          LOSS_COUNT = 3,
  parameter logic [15:0] SEED       = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data_in,
  input  logic        max_tick_in,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic        zero_err,
  output logic        period_ok,
  output logic        tick_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [15:0] nxt(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[14] ^ q[12] ^ q[3]};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] pred_q, pred_d;
  logic [15:0] ref_q, ref_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  match_q, match_d;
  logic [7:0]  miss_q, miss_d;
  logic [15:0] ecnt_d;
  logic        zero_d, err_d, per_d, tick_d;

  logic        is_zero, hit;
  logic [7:0]  match_inc, miss_inc;
  logic [15:0] wcnt_inc;

  assign is_zero   = (data_in == 16'h0000);
  assign hit       = (data_in == pred_q);
  assign match_inc = match_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;
  assign wcnt_inc  = wcnt_q + 16'd1;

`ifndef LFSR_CHK_TICK_EN
  logic unused_tick;
  assign unused_tick = max_tick_in | (SEED == 16'h0000);
`endif

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    ref_d   = ref_q;
    wcnt_d  = wcnt_q;
    match_d = match_q;
    miss_d  = miss_q;
    ecnt_d  = err_count;
    zero_d  = zero_err;
    err_d   = 1'b0;
    per_d   = 1'b0;
    tick_d  = 1'b0;
    if (data_valid) begin
      if (is_zero) zero_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (!is_zero) begin
            pred_d  = nxt(data_in);
            match_d = 8'd0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (hit) begin
            match_d = match_inc;
            pred_d  = nxt(data_in);
            if (match_inc == 8'(LOCK_COUNT)) begin
              state_d = LOCKED;
              ref_d   = data_in;
              wcnt_d  = 16'd0;
              miss_d  = 8'd0;
            end
          end else if (is_zero) begin
            // a zero word can never seed; start over
            match_d = 8'd0;
            state_d = IDLE;
          end else begin
            pred_d  = nxt(data_in);
            match_d = 8'd0;
          end
        end
        LOCKED: begin
          pred_d = nxt(pred_q);
          if (data_in == ref_q) begin
            per_d  = (wcnt_inc == 16'hFFFF);
            wcnt_d = 16'd0;
          end else begin
            wcnt_d = wcnt_inc;
          end
`ifdef LFSR_CHK_TICK_EN
          tick_d = max_tick_in != (data_in == SEED);
`endif
          if (hit) begin
            miss_d = 8'd0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (err_count != 16'hFFFF) ecnt_d = err_count + 16'd1;
            if (miss_inc == 8'(LOSS_COUNT)) begin
              match_d = 8'd0;
              if (is_zero) begin
                state_d = IDLE;
              end else begin
                pred_d  = nxt(data_in);
                state_d = ACQ;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pred_q    <= 16'd0;
      ref_q     <= 16'd0;
      wcnt_q    <= 16'd0;
      match_q   <= 8'd0;
      miss_q    <= 8'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 16'd0;
      zero_err  <= 1'b0;
      period_ok <= 1'b0;
      tick_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      ref_q     <= ref_d;
      wcnt_q    <= wcnt_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_d;
      err_count <= ecnt_d;
      zero_err  <= zero_d;
      period_ok <= per_d;
      tick_err  <= tick_d;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed scoreboard bench for lfsr_checker.
// Tick expectations follow LFSR_CHK_TICK_EN.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data_in;
  logic        max_tick_in;
  logic        locked, err_pulse, zero_err, period_ok, tick_err;
  logic [15:0] err_count;

  int passed = 0;
  int total  = 0;

`ifdef LFSR_CHK_TICK_EN
  localparam logic TICK_ON = 1'b1;
`else
  localparam logic TICK_ON = 1'b0;
`endif

  typedef struct packed {
    logic l;
    logic e;
    logic p;
    logic t;
  } exp_t;

  exp_t sb[$];
  logic [15:0] g;

  lfsr_checker dut (
    .clk(clk), .rst(rst),
    .data_valid(data_valid), .data_in(data_in),
    .max_tick_in(max_tick_in), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count),
    .zero_err(zero_err), .period_ok(period_ok),
    .tick_err(tick_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[14] ^ q[12] ^ q[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic v,
                      input logic [15:0] d, input logic t,
                      input logic el, input logic ee,
                      input logic et);
    exp_t e;
    sb.push_back('{l: el, e: ee, p: 1'b0, t: et});
    data_valid  = v;
    data_in     = d;
    max_tick_in = t;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".locked"}, 32'(locked), 32'(e.l));
    chk({tag, ".err"}, 32'(err_pulse), 32'(e.e));
    chk({tag, ".period"}, 32'(period_ok), 32'(e.p));
    chk({tag, ".tick"}, 32'(tick_err), 32'(e.t));
  endtask

  // send the generator's next word unmodified
  task automatic good(input string tag, input logic el);
    step(tag, 1'b1, g, g == 16'h0001, el, 1'b0, 1'b0);
    g = nxt(g);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".locked"}, 32'(locked), 32'd0);
    chk({tag, ".err"}, 32'(err_pulse), 32'd0);
    chk({tag, ".ecnt"}, 32'(err_count), 32'd0);
    chk({tag, ".zero"}, 32'(zero_err), 32'd0);
    chk({tag, ".period"}, 32'(period_ok), 32'd0);
    chk({tag, ".tick"}, 32'(tick_err), 32'd0);
  endtask

  initial begin
    int n, pcount, pidx, errs, ticks, drops;
    logic v;
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = 16'h0;
    max_tick_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // acquisition from seed: lock after the 5th word
    g = 16'h0001;
    step("idle_gap", 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) good("acq", 1'b0);
    good("lock5", 1'b1);
    chk("clean.ecnt", 32'(err_count), 32'd0);

    // one full period with random idle cycles
    n = 0; pcount = 0; pidx = -1;
    errs = 0; ticks = 0; drops = 0;
    while (n < 65535) begin
      v = ($urandom_range(0, 9) != 0);
      data_valid = v;
      if (v) begin
        data_in = g;
        max_tick_in = (g == 16'h0001);
        g = nxt(g);
        n++;
      end else begin
        data_in = 16'($urandom);
        max_tick_in = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (period_ok) begin
        pcount++;
        pidx = v ? n : -1;
      end
      if (err_pulse) errs++;
      if (tick_err) ticks++;
      if (!locked) drops++;
    end
    chk("period.count", 32'(pcount), 32'd1);
    chk("period.index", 32'(pidx), 32'd65535);
    chk("period.errs", 32'(errs), 32'd0);
    chk("period.ticks", 32'(ticks), 32'd0);
    chk("period.drops", 32'(drops), 32'd0);
    chk("period.ecnt", 32'(err_count), 32'd0);

    // single bit flip
    step("flip", 1'b1, g ^ 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
    g = nxt(g);
    chk("flip.ecnt", 32'(err_count), 32'd1);
    good("flip.after1", 1'b1);
    good("flip.after2", 1'b1);

    // jump to an unrelated state: three misses, re-lock after 4 matches
    g = 16'hACE1;
    step("jump1", 1'b1, g, 1'b0, 1'b1, 1'b1, 1'b0);
    g = nxt(g);
    step("jump2", 1'b1, g, 1'b0, 1'b1, 1'b1, 1'b0);
    g = nxt(g);
    step("jump3", 1'b1, g, 1'b0, 1'b0, 1'b1, 1'b0);
    g = nxt(g);
    for (int i = 0; i < 3; i++) good("reacq", 1'b0);
    good("relock", 1'b1);
    chk("jump.ecnt", 32'(err_count), 32'd4);

    // all-zero word while locked
    chk("zero.before", 32'(zero_err), 32'd0);
    step("zero", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    g = nxt(g);
    chk("zero.sticky", 32'(zero_err), 32'd1);
    chk("zero.ecnt", 32'(err_count), 32'd5);
    good("zero.after1", 1'b1);
    good("zero.after2", 1'b1);
    chk("zero.held", 32'(zero_err), 32'd1);

    // forced tick on a non-seed word
    if (g == 16'h0001) good("skip_seed", 1'b1);
    step("tick", 1'b1, g, 1'b1, 1'b1, 1'b0, TICK_ON);
    g = nxt(g);
    good("tick.after", 1'b1);

    // asynchronous reset mid-stream
    data_valid = 1'b1;
    data_in = g;
    rst = 1'b1;
    #2;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) good("rst.acq", 1'b0);
    good("rst.relock", 1'b1);
    chk("rst.ecnt", 32'(err_count), 32'd0);
    chk("rst.zero", 32'(zero_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
